// File: rtl/audio_sample_interp_pkg.sv
// Shared audio definitions: interpolator FSM encoding and default sample format.
// Also referenced by dsm_dac users so the sample width stays consistent across the chain.
package audio_sample_interp_pkg;

  localparam int unsigned DataWidthDef  = 16;
  localparam int unsigned PrimeLevelDef = 2;

  typedef enum logic [0:0] {
    StPrime,
    StRun
  } interp_st_e;

endpackage

// File: rtl/sample_fifo.sv
// Small circular sample buffer with registered occupancy.
// A push at full is refused even if a pop happens in the same cycle.
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LevelW = PtrW + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              push_ok, pop_ok;

  assign full_o  = (level_q == LevelW'(DEPTH));
  assign push_ok = push_i & ~full_o;
  // Only entries present at the start of the cycle may leave.
  assign pop_ok  = pop_i & (level_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    level_d  = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/audio_sample_interp.sv
// Upsamples mixer samples by linear interpolation over 2^INTERP_SHIFT clocks per sample,
// with a priming buffer and a sticky underrun flag.
module audio_sample_interp
  import audio_sample_interp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DataWidthDef,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned INTERP_SHIFT = 5,
  parameter int unsigned PRIME_LEVEL  = PrimeLevelDef
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [DATA_WIDTH-1:0]         in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [DATA_WIDTH-1:0]         sample_o,
  output logic                          underrun_o,
  input  logic                          underrun_clr_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;
  // Wide enough for (target - prev) * phase without overflow.
  localparam int unsigned ProdW  = DATA_WIDTH + INTERP_SHIFT + 2;

  interp_st_e                     state_q, state_d;
  logic        [INTERP_SHIFT-1:0] phase_q, phase_d;
  logic signed [DATA_WIDTH-1:0]   prev_q, prev_d;
  logic signed [DATA_WIDTH-1:0]   target_q, target_d;
  logic signed [DATA_WIDTH-1:0]   sample_q, sample_d;
  logic                           underrun_q, underrun_d;

  logic                           fifo_pop, fifo_full, underrun_set;
  logic        [DATA_WIDTH-1:0]   fifo_head;
  logic        [LevelW-1:0]       fifo_level;

  logic signed [ProdW-1:0]        prev_ext, delta, phase_ext, prod, value;
  logic                           unused_value_msb;

  sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (in_valid_i & in_ready_o),
    .data_i  (in_data_i),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full)
  );

  assign in_ready_o   = ~fifo_full;
  assign fifo_level_o = fifo_level;
  assign sample_o     = sample_q;
  assign underrun_o   = underrun_q;

  // value = prev + floor((target - prev) * phase / 2^INTERP_SHIFT)
  always_comb begin
    prev_ext  = ProdW'(prev_q);
    delta     = ProdW'(target_q) - ProdW'(prev_q);
    phase_ext = ProdW'(phase_q);
    prod      = delta * phase_ext;
    value     = prev_ext + (prod >>> INTERP_SHIFT);
    sample_d  = value[DATA_WIDTH-1:0];
  end

  // Result is bounded by prev/target, so the dropped high bits are pure sign extension.
  assign unused_value_msb = ^value[ProdW-1:DATA_WIDTH];

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    prev_d       = prev_q;
    target_d     = target_q;
    fifo_pop     = 1'b0;
    underrun_set = 1'b0;
    case (state_q)
      StPrime: begin
        phase_d = '0;
        prev_d  = target_q;
        if (fifo_level >= LevelW'(PRIME_LEVEL)) begin
          fifo_pop = 1'b1;
          target_d = fifo_head;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (&phase_q) begin
          phase_d = '0;
          prev_d  = target_q;
          if (fifo_level != '0) begin
            fifo_pop = 1'b1;
            target_d = fifo_head;
          end else begin
            underrun_set = 1'b1;
            state_d      = StPrime;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = StPrime;
    endcase
    // A same-cycle underrun event takes priority over the clear request.
    underrun_d = underrun_set | (underrun_q & ~underrun_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StPrime;
      phase_q    <= '0;
      prev_q     <= '0;
      target_q   <= '0;
      sample_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      prev_q     <= prev_d;
      target_q   <= target_d;
      sample_q   <= sample_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_audio_sample_interp.sv
// Scoreboard bench for audio_sample_interp (P=4, depth 4, prime level 2, 16-bit samples).
module tb_audio_sample_interp;

  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int SHIFT = 2;
  localparam int PRIME = 2;
  localparam int P = 1 << SHIFT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] sample;
  logic          underrun;
  logic          underrun_clr = 1'b0;
  logic [2:0]    level;

  always #5 clk = ~clk;

  audio_sample_interp #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .INTERP_SHIFT (SHIFT),
    .PRIME_LEVEL  (PRIME)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .sample_o       (sample),
    .underrun_o     (underrun),
    .underrun_clr_i (underrun_clr),
    .fifo_level_o   (level)
  );

  int total = 0;
  int bad = 0;

  function void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    int smp;
    int lvl;
    int und;
    int rdy;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: a queue of pending samples and one linear segment prev->target.
  int m_fifo[$];
  int m_prev = 0, m_target = 0, m_phase = 0;
  bit m_run = 1'b0, m_und = 1'b0;

  function int floor_div(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_step();
    exp_t e;
    bit   acc, had_data, ev;
    if (!rst_n) begin
      m_fifo.delete();
      m_prev = 0; m_target = 0; m_phase = 0; m_run = 0; m_und = 0;
      e = '{smp: 0, lvl: 0, und: 0, rdy: 1};
      exp_q.push_back(e);
      return;
    end
    e.smp    = m_prev + floor_div((m_target - m_prev) * m_phase, P);
    acc      = in_valid && (m_fifo.size() < DEPTH);
    had_data = m_fifo.size() > 0;
    ev       = 1'b0;
    if (!m_run) begin
      if (m_fifo.size() >= PRIME) begin
        m_prev = m_target; m_target = m_fifo.pop_front(); m_run = 1;
      end
    end else if (m_phase == P - 1) begin
      m_prev  = m_target;
      m_phase = 0;
      if (had_data) m_target = m_fifo.pop_front();
      else begin
        m_run = 0; ev = 1'b1;
      end
    end else begin
      m_phase++;
    end
    if (underrun_clr) m_und = 0;
    if (ev) m_und = 1;
    if (acc) m_fifo.push_back(int'($signed(in_data)));
    e.lvl = m_fifo.size();
    e.und = int'(m_und);
    e.rdy = (m_fifo.size() < DEPTH) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: one expected record per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sample", int'($signed(sample)), e.smp);
        chk("level", int'(level), e.lvl);
        chk("underrun", int'(underrun), e.und);
        chk("ready", int'(in_ready), e.rdy);
      end
    end
  end

  // Driver: samples waiting in src are offered; valid is held until accepted.
  int src[$];
  int clr_prob = 0;
  bit clr_force = 1'b0;

  task automatic cycle(input int prob);
    bit acc;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    if (acc) void'(src.pop_front());
    #3;
    underrun_clr = clr_force || (int'($urandom_range(99)) < clr_prob);
    if (!(in_valid && !acc))
      in_valid = (src.size() > 0) && (int'($urandom_range(99)) < prob);
    if (in_valid) in_data = DW'(src[0]);
  endtask

  task automatic wait_drain(input int budget, input int prob);
    for (int i = 0; i < budget && src.size() > 0; i++) cycle(prob);
    chk("drain", src.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    src.delete();
    #1;
    chk("rst_sample", int'($signed(sample)), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(in_ready), 1);
    repeat (2) cycle(0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit seen;
    repeat (3) cycle(0);
    rst_n = 1'b1;

    // Ramp 0 -> 100 -> 200, then underrun and hold.
    src = '{100, 200};
    wait_drain(20, 100);
    repeat (16) cycle(0);
    chk("ramp_hold", int'($signed(sample)), 200);
    chk("ramp_underrun", int'(underrun), 1);
    clr_force = 1'b1;
    cycle(0);
    clr_force = 1'b0;
    cycle(0);
    chk("clr_alone", int'(underrun), 0);

    // Clear held high across an underrun event: set must win.
    src = '{300, 400};
    clr_force = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(100);
      seen = underrun;
    end
    chk("set_wins", int'(underrun), 1);
    cycle(0);
    clr_force = 1'b0;
    chk("clr_after", int'(underrun), 0);

    // Floor rounding on a small negative step.
    do_reset();
    src = '{0, -3};
    wait_drain(20, 100);
    repeat (10) cycle(0);

    // Full-scale swings.
    src = '{32767, -32768, 32767, -32768};
    wait_drain(40, 100);
    repeat (12) cycle(0);

    // Back-pressure: six samples offered back to back.
    do_reset();
    for (int i = 1; i <= 6; i++) src.push_back(i * 1000);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(100);
      seen = !in_ready;
    end
    chk("full_level", int'(level), DEPTH);
    wait_drain(60, 100);
    repeat (28) cycle(0);

    // Reset mid-ramp with three samples queued.
    do_reset();
    for (int i = 1; i <= 5; i++) src.push_back(-i * 700);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(100);
      seen = (level == 3'd3);
    end
    chk("queued3", int'(level), 3);
    do_reset();
    src = '{7};
    repeat (10) cycle(100);
    chk("prime_hold_sample", int'($signed(sample)), 0);
    chk("prime_hold_level", int'(level), 1);
    src.push_back(8);
    repeat (12) cycle(100);

    // Randomised traffic with varying rates and occasional clears.
    clr_prob = 5;
    for (int blk = 0; blk < 8; blk++) begin
      int prob;
      prob = int'($urandom_range(100));
      for (int i = 0; i < 20; i++) src.push_back(int'($signed(16'($urandom))));
      for (int i = 0; i < 50; i++) cycle(prob);
    end
    src.delete();
    in_valid = 1'b0;
    clr_prob = 0;
    repeat (4) cycle(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
